// File: rtl/pipe_pkg.sv
// Shared pipeline types: field widths, ALUOp encodings and the EX control bundle.
// The all-zero control bundle is the canonical bubble (ALUOp add, no writes).
package pipe_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNC3_W = 3;
  localparam int unsigned FUNC7_W = 7;
  localparam int unsigned ALUOP_W = 2;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

  // Squash control for an ID slot that holds no real instruction.
  function automatic ex_ctrl_t gate_ctrl(input ex_ctrl_t ctrl, input logic valid);
    return valid ? ctrl : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side operand/control inputs and EX-side registered outputs of the ID/EX boundary.
interface id_ex_stage_if #(
  parameter int unsigned XLEN = 32
);
  import pipe_pkg::*;

  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [REG_W-1:0]      id_rs1;
  logic [REG_W-1:0]      id_rs2;
  logic [REG_W-1:0]      id_rd;
  logic [FUNC3_W-1:0]    id_func3;
  logic [FUNC7_W-1:0]    id_func7;
  logic [ALUOP_W-1:0]    id_alu_op;
  logic                  id_alu_src;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_reg_write;
  logic                  id_mem_to_reg;
  logic                  id_branch;

  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [XLEN-1:0]       ex_imm;
  logic [REG_W-1:0]      ex_rs1;
  logic [REG_W-1:0]      ex_rs2;
  logic [REG_W-1:0]      ex_rd;
  logic [FUNC3_W-1:0]    ex_func3;
  logic [FUNC7_W-1:0]    ex_func7;
  logic [ALUOP_W-1:0]    ex_alu_op;
  logic                  ex_alu_src;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_reg_write;
  logic                  ex_mem_to_reg;
  logic                  ex_branch;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_func3, id_func7, id_alu_op,
           id_alu_src, id_mem_read, id_mem_write, id_reg_write,
           id_mem_to_reg, id_branch,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_func3, ex_func7, ex_alu_op,
           ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg, ex_branch
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_func3, id_func7, id_alu_op,
           id_alu_src, id_mem_read, id_mem_write, id_reg_write,
           id_mem_to_reg, id_branch,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_func3, ex_func7, ex_alu_op,
           ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg, ex_branch
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector and front-end stall request.
// A flush squashes the dependent ID instruction, so it also cancels the stall.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_flush,
  input  logic             i_hold,
  output logic             o_load_use,
  output logic             o_stall
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = |i_ex_rd;
  assign w_src_match  = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);

  assign o_load_use = i_ex_valid & i_ex_mem_read & w_rd_nonzero & i_id_valid & w_src_match;
  assign o_stall    = ~i_flush & (i_hold | o_load_use);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, external hold
// and a saturating count of inserted load-use bubbles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  id_ex_stage_if.slave      pipe,
  input  logic              flush,
  input  logic              hold_in,
  output logic              stall_out,
  output logic [CNT_W-1:0]  lu_stall_cnt
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [REG_W-1:0]      r_rs1;
  logic [REG_W-1:0]      r_rs2;
  logic [REG_W-1:0]      r_rd;
  logic [FUNC3_W-1:0]    r_func3;
  logic [FUNC7_W-1:0]    r_func7;
  ex_ctrl_t              r_ctrl;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_load_use;
  logic                  w_stall;
  logic                  w_bubble;
  logic                  w_capture;
  logic                  w_count;
  ex_ctrl_t              w_id_ctrl;

  hazard_detect u_hazard (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rd       (r_rd),
    .i_id_valid    (pipe.id_valid),
    .i_id_rs1      (pipe.id_rs1),
    .i_id_rs2      (pipe.id_rs2),
    .i_flush       (flush),
    .i_hold        (hold_in),
    .o_load_use    (w_load_use),
    .o_stall       (w_stall)
  );

  assign stall_out = w_stall;

  // Priority: flush > hold > load-use bubble > normal capture.
  assign w_bubble  = flush | (~hold_in & w_load_use);
  assign w_capture = ~flush & ~hold_in & ~w_load_use;
  assign w_count   = ~flush & ~hold_in & w_load_use;

  assign w_id_ctrl = '{
    alu_op:     pipe.id_alu_op,
    alu_src:    pipe.id_alu_src,
    mem_read:   pipe.id_mem_read,
    mem_write:  pipe.id_mem_write,
    reg_write:  pipe.id_reg_write,
    mem_to_reg: pipe.id_mem_to_reg,
    branch:     pipe.id_branch
  };

  // Stage register: bubbles clear everything, hold keeps, capture loads ID.
  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_func3    <= '0;
      r_func7    <= '0;
      r_ctrl     <= CTRL_BUBBLE;
    end else if (w_capture) begin
      r_valid    <= pipe.id_valid;
      r_pc       <= pipe.id_pc;
      r_rs1_data <= pipe.id_rs1_data;
      r_rs2_data <= pipe.id_rs2_data;
      r_imm      <= pipe.id_imm;
      r_rs1      <= pipe.id_rs1;
      r_rs2      <= pipe.id_rs2;
      r_rd       <= pipe.id_rd;
      r_func3    <= pipe.id_func3;
      r_func7    <= pipe.id_func7;
      r_ctrl     <= gate_ctrl(w_id_ctrl, pipe.id_valid);
    end
  end

  // Saturating load-use bubble counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_count && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign lu_stall_cnt = r_cnt;

  assign pipe.ex_valid      = r_valid;
  assign pipe.ex_pc         = r_pc;
  assign pipe.ex_rs1_data   = r_rs1_data;
  assign pipe.ex_rs2_data   = r_rs2_data;
  assign pipe.ex_imm        = r_imm;
  assign pipe.ex_rs1        = r_rs1;
  assign pipe.ex_rs2        = r_rs2;
  assign pipe.ex_rd         = r_rd;
  assign pipe.ex_func3      = r_func3;
  assign pipe.ex_func7      = r_func7;
  assign pipe.ex_alu_op     = r_ctrl.alu_op;
  assign pipe.ex_alu_src    = r_ctrl.alu_src;
  assign pipe.ex_mem_read   = r_ctrl.mem_read;
  assign pipe.ex_mem_write  = r_ctrl.mem_write;
  assign pipe.ex_reg_write  = r_ctrl.reg_write;
  assign pipe.ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign pipe.ex_branch     = r_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts the EX state per edge,
// checked against a 16-bit-counter instance and a 2-bit-counter instance.
module tb_id_ex_stage;
  import pipe_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  op;
    logic        src, mr, mw, rw, m2r, br;
  } stim_t;

  typedef struct packed {
    stim_t       st;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        hold_in = 1'b0;
  logic        stall_a, stall_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  stim_t       s = '0;
  stim_t       m = '0;
  int unsigned mcnt = 0;
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_err = 0;

  id_ex_stage_if #(.XLEN(32)) ifa ();
  id_ex_stage_if #(.XLEN(32)) ifb ();

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .pipe(ifa.slave), .flush(flush),
    .hold_in(hold_in), .stall_out(stall_a), .lu_stall_cnt(cnt_a)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .pipe(ifb.slave), .flush(flush),
    .hold_in(hold_in), .stall_out(stall_b), .lu_stall_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply();
    ifa.id_valid = s.valid;   ifb.id_valid = s.valid;
    ifa.id_pc = s.pc;         ifb.id_pc = s.pc;
    ifa.id_rs1_data = s.d1;   ifb.id_rs1_data = s.d1;
    ifa.id_rs2_data = s.d2;   ifb.id_rs2_data = s.d2;
    ifa.id_imm = s.imm;       ifb.id_imm = s.imm;
    ifa.id_rs1 = s.rs1;       ifb.id_rs1 = s.rs1;
    ifa.id_rs2 = s.rs2;       ifb.id_rs2 = s.rs2;
    ifa.id_rd = s.rd;         ifb.id_rd = s.rd;
    ifa.id_func3 = s.f3;      ifb.id_func3 = s.f3;
    ifa.id_func7 = s.f7;      ifb.id_func7 = s.f7;
    ifa.id_alu_op = s.op;     ifb.id_alu_op = s.op;
    ifa.id_alu_src = s.src;   ifb.id_alu_src = s.src;
    ifa.id_mem_read = s.mr;   ifb.id_mem_read = s.mr;
    ifa.id_mem_write = s.mw;  ifb.id_mem_write = s.mw;
    ifa.id_reg_write = s.rw;  ifb.id_reg_write = s.rw;
    ifa.id_mem_to_reg = s.m2r; ifb.id_mem_to_reg = s.m2r;
    ifa.id_branch = s.br;     ifb.id_branch = s.br;
  endtask

  function automatic stim_t snap_a();
    return '{valid: ifa.ex_valid, pc: ifa.ex_pc, d1: ifa.ex_rs1_data, d2: ifa.ex_rs2_data,
             imm: ifa.ex_imm, rs1: ifa.ex_rs1, rs2: ifa.ex_rs2, rd: ifa.ex_rd,
             f3: ifa.ex_func3, f7: ifa.ex_func7, op: ifa.ex_alu_op, src: ifa.ex_alu_src,
             mr: ifa.ex_mem_read, mw: ifa.ex_mem_write, rw: ifa.ex_reg_write,
             m2r: ifa.ex_mem_to_reg, br: ifa.ex_branch};
  endfunction

  function automatic stim_t snap_b();
    return '{valid: ifb.ex_valid, pc: ifb.ex_pc, d1: ifb.ex_rs1_data, d2: ifb.ex_rs2_data,
             imm: ifb.ex_imm, rs1: ifb.ex_rs1, rs2: ifb.ex_rs2, rd: ifb.ex_rd,
             f3: ifb.ex_func3, f7: ifb.ex_func7, op: ifb.ex_alu_op, src: ifb.ex_alu_src,
             mr: ifb.ex_mem_read, mw: ifb.ex_mem_write, rw: ifb.ex_reg_write,
             m2r: ifb.ex_mem_to_reg, br: ifb.ex_branch};
  endfunction

  function automatic stim_t rnd_stim();
    stim_t r;
    r.valid = 1'b1;
    r.pc = $urandom; r.d1 = $urandom; r.d2 = $urandom; r.imm = $urandom;
    r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
    r.f3 = 3'($urandom); r.f7 = 7'($urandom); r.op = 2'($urandom_range(0, 2));
    r.src = 1'($urandom); r.mr = 1'($urandom); r.mw = 1'($urandom);
    r.rw = 1'($urandom); r.m2r = 1'($urandom); r.br = 1'($urandom);
    return r;
  endfunction

  function automatic stim_t mk_lw(input logic [4:0] rd, input logic [4:0] base);
    stim_t r = rnd_stim();
    r.rs1 = base; r.rs2 = 5'd0; r.rd = rd; r.f3 = 3'b010; r.f7 = 7'd0;
    r.op = ALUOP_ADD; r.src = 1'b1; r.mr = 1'b1; r.mw = 1'b0;
    r.rw = 1'b1; r.m2r = 1'b1; r.br = 1'b0;
    return r;
  endfunction

  function automatic stim_t mk_r(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    stim_t r = rnd_stim();
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.f3 = 3'b000; r.f7 = 7'b0000000;
    r.op = ALUOP_RTYPE; r.src = 1'b0; r.mr = 1'b0; r.mw = 1'b0;
    r.rw = 1'b1; r.m2r = 1'b0; r.br = 1'b0;
    return r;
  endfunction

  // One clock: drive s with the given controls, check stall, predict, then compare.
  task automatic step(input logic rst, input logic fl, input logic hd, input bit chk_stall);
    logic  lu, st;
    exp_t  e;
    stim_t oa;
    reset = rst; flush = fl; hold_in = hd;
    apply();
    #1;
    lu = m.valid & m.mr & (m.rd != 5'd0) & s.valid & ((m.rd == s.rs1) | (m.rd == s.rs2));
    st = ~fl & (hd | lu);
    if (chk_stall) begin
      check_eq("stall_out", 256'(stall_a), 256'(st));
      check_eq("stall_out_b", 256'(stall_b), 256'(st));
    end
    if (rst) begin
      m = '0; mcnt = 0;
    end else if (fl) begin
      m = '0;
    end else if (hd) begin
      m = m;
    end else if (lu) begin
      m = '0;
      if (mcnt < 65535) mcnt++;
    end else begin
      m = s;
      if (!s.valid) begin
        m.op = 2'b00; m.src = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
        m.rw = 1'b0; m.m2r = 1'b0; m.br = 1'b0;
      end
    end
    e.st = m; e.c16 = 16'(mcnt); e.c2 = (mcnt > 3) ? 2'd3 : 2'(mcnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 256'(1), 256'(0));
    end else begin
      e  = sb_q.pop_front();
      oa = snap_a();
      check_eq("ex_valid", 256'(oa.valid), 256'(e.st.valid));
      check_eq("ex_ctrl", 256'({oa.op, oa.src, oa.mr, oa.mw, oa.rw, oa.m2r, oa.br}),
               256'({e.st.op, e.st.src, e.st.mr, e.st.mw, e.st.rw, e.st.m2r, e.st.br}));
      check_eq("ex_idx", 256'({oa.rs1, oa.rs2, oa.rd, oa.f3, oa.f7}),
               256'({e.st.rs1, e.st.rs2, e.st.rd, e.st.f3, e.st.f7}));
      check_eq("ex_data", 256'({oa.pc, oa.d1, oa.d2, oa.imm}),
               256'({e.st.pc, e.st.d1, e.st.d2, e.st.imm}));
      check_eq("ex_state_b", 256'(snap_b()), 256'(e.st));
      check_eq("lu_cnt16", 256'(cnt_a), 256'(e.c16));
      check_eq("lu_cnt2", 256'(cnt_b), 256'(e.c2));
    end
  endtask

  initial begin
    s = rnd_stim();
    apply();
    @(posedge clk);
    #1;

    // Reset with random ID inputs
    step(1'b1, 1'b0, 1'b0, 1'b0);
    s = rnd_stim();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("reset_cnt", 256'(cnt_a), 256'(0));
    check_eq("reset_valid", 256'(ifa.ex_valid), 256'(0));

    // Pass-through of an R-type instruction
    s = mk_r(5'd1, 5'd2, 5'd5); s.f7 = 7'b0100000;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("pt_alu_op", 256'(ifa.ex_alu_op), 256'(2'b10));
    check_eq("pt_func7", 256'(ifa.ex_func7), 256'(7'b0100000));
    check_eq("pt_rd", 256'(ifa.ex_rd), 256'(5));

    // Load-use: lw x7 then add using x7
    s = mk_lw(5'd7, 5'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    s = mk_r(5'd7, 5'd3, 5'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("lu_bubble_valid", 256'(ifa.ex_valid), 256'(0));
    check_eq("lu_cnt_one", 256'(cnt_a), 256'(1));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("lu_advance_rd", 256'(ifa.ex_rd), 256'(8));

    // rd = x0 never stalls
    s = mk_lw(5'd0, 5'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    s = mk_r(5'd0, 5'd0, 5'd9);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush together with hold, then hold alone for 3 cycles
    s = mk_lw(5'd9, 5'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    s = mk_r(5'd9, 5'd1, 5'd10);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    s = mk_r(5'd11, 5'd12, 5'd13);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      s = rnd_stim();
      step(1'b0, 1'b0, 1'b1, 1'b1);
    end

    // Hold and load-use together: hold wins until it drops
    s = mk_lw(5'd4, 5'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    s = mk_r(5'd2, 5'd4, 5'd6);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Invalid ID slot: control squashed, data captured
    s = rnd_stim(); s.valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Saturation from a cleared counter: 5 load-use events
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      s = mk_lw(5'(i + 1), 5'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      s = mk_r(5'(i + 1), 5'd0, 5'd20);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_eq("sat_cnt2", 256'(cnt_b), 256'(3));

    // Reset in the middle of a load-use stall
    s = mk_lw(5'd6, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    s = mk_r(5'd6, 5'd6, 5'd7);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 80; i++) begin
      s = rnd_stim();
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.valid = ($urandom_range(0, 7) != 0);
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 5) == 0), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage pipelined core.
- Registers decoded operands and control from ID into EX; its EX-side outputs drive ALU operand muxing and ALU control decoding (ALUOp, func3, func7).
- Contains load-use hazard detection: requests an IF/ID hold and inserts a bubble.
- Handles branch flush, external hold, and a saturating load-use stall counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of load-use stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_func3  in  3  instruction func3.
- id_func7  in  7  instruction func7.
- id_alu_op  in  2  ALUOp (00 add, 01 sub/branch, 10 R-type).
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each  control bits.
- flush  in  1  branch taken / redirect resolved in EX.
- hold_in  in  1  downstream stall; freeze this stage.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5  registered copies.
- ex_func3  out  3, ex_func7  out  7, ex_alu_op  out  2  registered.
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1 each  registered.
- stall_out  out  1  combinational; holds PC and IF/ID.
- lu_stall_cnt  out  CNT_W  load-use bubbles inserted.

Behaviour:
- Reset (sync, reset=1 at clk edge):
  - All ex_* outputs go to 0. This is the canonical bubble: ALUOp 00, no writes.
  - lu_stall_cnt goes to 0.
  - Reset overrides every other input.
- load_use = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- stall_out = ~flush & (hold_in | load_use); purely combinational, no added latency.
- Per-edge priority when not in reset:
  1. flush=1: load bubble. All control bits and ex_valid cleared; data fields cleared. Overrides hold_in.
  2. hold_in=1: all ex_* registers keep their values, no bubble, counter unchanged.
  3. load_use=1: load bubble; lu_stall_cnt += 1.
  4. Otherwise: capture all id_* into ex_*; ex_valid = id_valid.
- id_valid=0 on a normal load yields ex_valid=0 and all control bits forced 0. Data fields are still captured.
- lu_stall_cnt saturates at all-ones and never wraps.
- Latency: exactly one cycle from ID inputs to ex_* outputs.
- A load-use stall lasts one cycle. On the next edge EX holds the bubble, so load_use drops and the held ID instruction advances.
- rd = x0 never causes a stall.
- Simultaneous hold_in and load_use: hold wins, no bubble, no count. The stall persists until hold_in drops.
- Reset in mid-stall: bubble state, counter cleared, stall_out re-evaluated from inputs (0 after reset, since ex_valid=0).

Decomposition:
- Shared package pipe_pkg:
  - ALUOp encodings (ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10).
  - Ex-control bundle field list.
  - Bubble constant (all-zero control).
- One sub-module: hazard_detect, the combinational load_use/stall_out generator. It is instantiated here and reusable for later forwarding work.

Test Plan:
- Reset: assert reset 2 cycles with random id_* -> all ex_* = 0, lu_stall_cnt = 0, stall_out = 0.
- Pass-through: id_valid=1, id_alu_op=10, func3=000, func7=0100000, rd=5 -> next cycle ex_alu_op=10, ex_func7=0100000, ex_rd=5, ex_valid=1.
- Load-use: EX = lw x7 (mem_read=1, rd=7), ID = add rs1=7 -> stall_out=1 that cycle; next edge ex_valid=0, ex_mem_read=0, lu_stall_cnt=1; following edge the add appears in EX and stall_out=0.
- No stall on x0: EX lw rd=0, ID rs1=0 -> stall_out=0, no bubble, counter unchanged.
- Flush vs hold: flush=1 and hold_in=1 together -> stall_out=0 and next edge is a bubble. hold_in=1 alone for 3 cycles -> ex_* unchanged, stall_out=1.
- Saturation: CNT_W=2, force 5 load-use events -> lu_stall_cnt reads 1, 2, 3, 3, 3.
